// File: rtl/dmem_arbiter.sv
// dmem_arbiter: A-priority two-port arbiter in front of my_dmem.
// Define DMEM_ARB_STARVE_EN to build the wait counter and the FORCE_B starvation guard.
module dmem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_opt,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_stall,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_opt,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic              mem_e,
  output logic              mem_r,
  output logic              mem_w,
  output logic [1:0]        mem_opt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);
  logic force_b, sel_b, req, we;
`ifdef DMEM_ARB_STARVE_EN
  localparam int WW = $clog2(MAX_WAIT) + 1;
  localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);
  typedef enum logic {A_OWN, FORCE_B} state_t;
  state_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= A_OWN;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end
  // Only a blocked B in A_OWN counts; anything else (idle, ack, forced cycle) clears.
  always_comb begin
    state_n = A_OWN;
    wcnt_n  = '0;
    if (state == A_OWN && a_req && b_req) begin
      state_n = (wcnt == WLAST) ? FORCE_B : A_OWN;
      wcnt_n  = (wcnt == WLAST) ? '0 : wcnt + 1'b1;
    end
  end
  assign force_b = (state == FORCE_B) & ~reset;
`else
  logic unused_max_wait;
  assign unused_max_wait = MAX_WAIT > 0;
  assign force_b = 1'b0;
`endif
  assign sel_b     = ~reset & (force_b | (~a_req & b_req));
  assign req       = ~reset & (sel_b ? b_req : a_req);
  assign we        = sel_b ? b_we : a_we;
  assign owner     = sel_b;
  assign mem_e     = req;
  assign mem_r     = req & ~we;
  assign mem_w     = req & we;
  assign mem_opt   = sel_b ? b_opt : a_opt;
  assign mem_addr  = sel_b ? b_addr : a_addr;
  assign mem_wdata = sel_b ? b_wdata : a_wdata;
  assign b_ack     = sel_b & b_req;
  assign a_stall   = force_b;
  assign a_rdata   = mem_rdata;
  assign b_rdata   = mem_rdata;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-port data memory (`my_dmem`). It shares the memory between the single-cycle CPU (port A) and a secondary requester (port B), such as a program loader or debug port. Port A has priority, so normal execution proceeds without stalls. Port B is served in cycles where the CPU does not access memory. An optional starvation guard forces one B access after a bounded wait by stalling the CPU for one cycle. The block sits between `cpu` and `my_dmem` inside the top-level dataflow module.

## Interface
Parameters:
- `ADDR_W`, default 6: word/byte address width presented to `my_dmem`.
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 8: number of consecutive blocked B cycles before a forced B grant (≥1).

Ports:
- `clk_in` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `a_req` in 1: CPU memory access this cycle (maps from `DM_E`).
- `a_we` in 1: CPU write (1) / read (0).
- `a_opt` in 2: CPU access size code, passed through unchanged.
- `a_addr` in `ADDR_W`: CPU address.
- `a_wdata` in `DATA_W`: CPU write data.
- `a_rdata` out `DATA_W`: CPU read data.
- `a_stall` out 1: CPU must hold PC and suppress writeback this cycle.
- `b_req`, `b_we`, `b_opt[1:0]`, `b_addr`, `b_wdata`: in, same meaning for port B.
- `b_rdata` out `DATA_W`: B read data, valid when `b_ack`=1.
- `b_ack` out 1: B access performed this cycle; the write commits at the next edge.
- `mem_e`, `mem_r`, `mem_w` out 1: memory enable, read and write strobes.
- `mem_opt` out 2, `mem_addr` out `ADDR_W`, `mem_wdata` out `DATA_W`: memory request.
- `mem_rdata` in `DATA_W`: combinational read data from memory.
- `owner` out 1: 0 = A selected, 1 = B selected (combinational, current cycle).

## Operation
- FSM states are `A_OWN` (reset state) and `FORCE_B`.
- `A_OWN`:
  - If `a_req`=1, select A.
  - Else if `b_req`=1, select B and assert `b_ack`.
  - Else select A with strobes low.
- `FORCE_B`:
  - Select B.
  - `b_ack`=1 when `b_req`=1.
  - `a_stall`=1.
  - Next state is `A_OWN` unconditionally.
- Strobes for the selected requester: `mem_e`=req, `mem_r`=req & ~we, `mem_w`=req & we. Address, data and opt are muxed from the selected port.
- `a_rdata` and `b_rdata` both carry `mem_rdata`. Each is meaningful only to its owner.
- Wait counter `wcnt` (width clog2(`MAX_WAIT`)+1):
  - Increments each cycle in `A_OWN` with `a_req` & `b_req`.
  - Clears when `b_req`=0 or B is acked.
  - When `wcnt` = `MAX_WAIT`-1 and B is still blocked, the next state is `FORCE_B`.
- `b_req` dropped in `FORCE_B`: the cycle is spent idle (strobes low), `a_stall` stays 1, and the FSM returns to `A_OWN`.
- Simultaneous `a_req` and `b_req` in `A_OWN`: A always wins.

## Timing
- Reset values: state `A_OWN`, `wcnt`=0.
- While `reset`=1: `a_stall`=0, `b_ack`=0, `mem_w`=0, `mem_e`=0.
- Reset asserted in `FORCE_B` returns the FSM to `A_OWN` on the next edge.
- A access latency is 0 cycles (combinational path to memory) whenever `a_stall`=0.
- B latency:
  - 0 cycles when A is idle.
  - With the guard compiled in, at most `MAX_WAIT`+1 cycles from `b_req` rising to `b_ack`.
- B holds its request signals stable until `b_ack`=1.
- A repeats its access in the cycle after `a_stall`.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: `wcnt` and the `FORCE_B` state are present, with behaviour as above.
- `DMEM_ARB_STARVE_EN` undefined:
  - Pure fixed priority; no counter or `FORCE_B` logic is built.
  - `a_stall` is tied to 0.
  - B is served only in cycles with `a_req`=0.

## Test plan
- Reset: hold `reset` for 2 cycles with both requests high -> `a_stall`=0, `b_ack`=0, `mem_w`=0; after release, `owner`=0.
- A write: `a_req`=1, `a_we`=1, `a_addr`=5, `a_wdata`=0xDEADBEEF -> `mem_w`=1, `mem_addr`=5, `mem_wdata`=0xDEADBEEF, `b_ack`=0.
- B read while A idle: `b_req`=1, `b_we`=0, `b_addr`=3, with memory returning 0x12345678 -> same cycle `b_ack`=1, `owner`=1, `b_rdata`=0x12345678.
- Starvation (`MAX_WAIT`=8, guard on): `a_req` and `b_req` both held high:
  - Cycles 1–8: `b_ack`=0.
  - Cycle 9: `a_stall`=1, `b_ack`=1, `mem_addr`=`b_addr`.
  - Cycle 10: `a_stall`=0, `owner`=0.
- Wait-counter clear (guard on): B blocked 5 cycles, then `b_req`=0 for 1 cycle, then reasserted -> a fresh 8 blocked cycles are required before `FORCE_B`. With the guard off, `b_ack` never rises while `a_req`=1.
- Reset during `FORCE_B` -> next cycle in `A_OWN`, `a_stall`=0, `wcnt`=0, and no B write committed.
